uart16550_rx_fifo_ctrl: RTL and testbench

- Receive-side controller for the 16-deep UART 16550 FIFO (8-bit data, push/pop handshake, empty/full/overrun/threshold flags).
- Sequences pushes from the RX shifter and pops from CPU reads of RBR.
- Applies FCR control: FIFO enable, RX reset and trigger level.
- Generates the line-status bits data_ready and overrun_err, plus the received-data-available and character-timeout interrupts.

---
 rtl/uart16550_pkg.sv | 31 +++
 rtl/uart16550_rx_fifo_ctrl_to_cnt.sv | 21 ++
 rtl/uart16550_rx_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_uart16550_rx_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart16550_pkg.sv
// Shared types and helpers for the UART 16550 receive path.
package uart16550_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int DW         = 8;

    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        EMPTY   = 2'd1,
        HOLD    = 2'd2,
        TIMEOUT = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_e;

    // The FIFO compares its pre-push write address, so the threshold is level-1.
    function automatic logic [3:0] trig_to_threshold(input trig_e trig);
        case (trig)
            TRIG_1:  return 4'd0;
            TRIG_4:  return 4'd3;
            TRIG_8:  return 4'd7;
            default: return 4'd13;
        endcase
    endfunction

endpackage

// File: rtl/uart16550_rx_fifo_ctrl_to_cnt.sv
// Saturating character-timeout counter; built only when UART_RX_CTI_EN is defined.
module uart_rx_timeout_cnt #(
    parameter int TO_W  = 3,
    parameter int LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            tick,
    output logic [TO_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick && (cnt != LIMIT[TO_W-1:0])) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart16550_rx_fifo_ctrl.sv
// RX FIFO controller for a 16550-style UART: push/pop sequencing, FCR handling, LSR bits and RX interrupts.
// Optional macro UART_RX_CTI_EN builds the character-timeout counter, TIMEOUT state and irq_cti.
module uart16550_rx_fifo_ctrl #(
    parameter int DW            = 8,
    parameter int TIMEOUT_CHARS = 4,
    parameter int TO_W          = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic          char_tick,
    input  logic          fcr_fifo_en,
    input  logic          fcr_rx_rst,
    input  logic [1:0]    fcr_trig,
    input  logic          rbr_rd,
    input  logic          lsr_rd,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          fifo_thre,
    output logic          fifo_rst,
    output logic          fifo_push,
    output logic          fifo_pop,
    output logic [DW-1:0] fifo_din,
    output logic [3:0]    fifo_threshold,
    output logic [DW-1:0] rbr_data,
    output logic          data_ready,
    output logic          overrun_err,
    output logic          irq_rda,
    output logic          irq_cti
);
    import uart16550_pkg::*;

    rx_state_e state;
    logic      fifo_en_q;
    logic      vld_p0;
    logic      pop_p0;
    logic      in_flush;
    logic      flush_req;
    logic      blocked;

    assign in_flush  = (state == FLUSH);
    assign flush_req = fcr_rx_rst | (fcr_fifo_en != fifo_en_q);

    // In holding-register mode a push only lands in an empty FIFO, giving depth 1.
    assign fifo_push = vld_p0 & ~fifo_full & (fifo_en_q | fifo_empty) & ~in_flush;
    assign blocked   = vld_p0 & ~fifo_push & ~in_flush;
    assign fifo_pop  = rbr_rd & ~fifo_empty & ~in_flush;

    assign fifo_rst   = in_flush;
    assign data_ready = ~fifo_empty & ~in_flush;
    assign rbr_data   = data_ready ? fifo_dout : '0;
    assign irq_rda    = fifo_en_q ? (fifo_thre & data_ready) : data_ready;

`ifdef UART_RX_CTI_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_clr;

    assign to_clr = fifo_push | fifo_pop | (state == EMPTY) | in_flush | ~fifo_en_q;

    uart_rx_timeout_cnt #(
        .TO_W (TO_W),
        .LIMIT(TIMEOUT_CHARS)
    ) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (to_clr),
        .tick(char_tick),
        .cnt (to_cnt)
    );

    assign irq_cti = (state == TIMEOUT);
`else
    logic unused_tick;
    localparam int unused_to_cfg = TIMEOUT_CHARS + TO_W;

    assign unused_tick = char_tick;
    assign irq_cti     = 1'b0;
`endif

    // stage p0: received character waits one cycle for the full/empty gate
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            fifo_din <= '0;
        end else begin
            vld_p0 <= rx_valid & ~in_flush & ~flush_req;
            if (rx_valid) begin
                fifo_din <= rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FLUSH;
            fifo_en_q      <= fcr_fifo_en;
            pop_p0         <= 1'b0;
            overrun_err    <= 1'b0;
            fifo_threshold <= '0;
        end else begin
            fifo_en_q      <= fcr_fifo_en;
            pop_p0         <= fifo_pop;
            fifo_threshold <= trig_to_threshold(trig_e'(fcr_trig));

            if (blocked) begin
                overrun_err <= 1'b1;
            end else if (lsr_rd) begin
                overrun_err <= 1'b0;
            end

            if (flush_req) begin
                state <= FLUSH;
            end else begin
                case (state)
                    FLUSH: state <= EMPTY;
                    EMPTY: if (fifo_push) state <= HOLD;
                    default: begin
                        if (pop_p0 && fifo_empty && !fifo_push) begin
                            state <= EMPTY;
                        end else if (fifo_push || fifo_pop) begin
                            state <= HOLD;
`ifdef UART_RX_CTI_EN
                        end else if (to_cnt == TIMEOUT_CHARS[TO_W-1:0]) begin
                            state <= TIMEOUT;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart16550_rx_fifo_ctrl.sv
// Directed bench for uart16550_rx_fifo_ctrl with a behavioural 16-entry FIFO attached.
module tb_uart16550_rx_fifo_ctrl;

`ifdef UART_RX_CTI_EN
    localparam logic CTI_ON = 1'b1;
`else
    localparam logic CTI_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx_valid, char_tick, fcr_fifo_en, fcr_rx_rst, rbr_rd, lsr_rd;
    logic [7:0] rx_data, fifo_dout, fifo_din, rbr_data;
    logic [1:0] fcr_trig;
    logic       fifo_empty, fifo_full, fifo_thre;
    logic       fifo_rst, fifo_push, fifo_pop, data_ready, overrun_err, irq_rda, irq_cti;
    logic [3:0] fifo_threshold;

    uart16550_rx_fifo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .char_tick     (char_tick),
        .fcr_fifo_en   (fcr_fifo_en),
        .fcr_rx_rst    (fcr_rx_rst),
        .fcr_trig      (fcr_trig),
        .rbr_rd        (rbr_rd),
        .lsr_rd        (lsr_rd),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_thre     (fifo_thre),
        .fifo_rst      (fifo_rst),
        .fifo_push     (fifo_push),
        .fifo_pop      (fifo_pop),
        .fifo_din      (fifo_din),
        .fifo_threshold(fifo_threshold),
        .rbr_data      (rbr_data),
        .data_ready    (data_ready),
        .overrun_err   (overrun_err),
        .irq_rda       (irq_rda),
        .irq_cti       (irq_cti)
    );

    // Behavioural FIFO: thre asserts once the fill level exceeds the threshold.
    logic [7:0] fmem [16];
    logic [3:0] fwr = '0, frd = '0;
    logic [4:0] fcnt = '0;
    logic       do_wr, do_rd;

    assign do_wr      = fifo_push && (fcnt < 5'd16);
    assign do_rd      = fifo_pop && (fcnt != 5'd0);
    assign fifo_empty = (fcnt == 5'd0);
    assign fifo_full  = (fcnt == 5'd16);
    assign fifo_thre  = (fcnt > {1'b0, fifo_threshold});
    assign fifo_dout  = fmem[frd];

    always @(posedge clk) begin
        if (fifo_rst) begin
            fwr  <= '0;
            frd  <= '0;
            fcnt <= '0;
        end else begin
            if (do_wr) begin
                fmem[fwr] <= fifo_din;
                fwr       <= fwr + 4'd1;
            end
            if (do_rd) frd <= frd + 4'd1;
            fcnt <= fcnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    logic       lvl_rst = 1'b1;
    logic       lvl_en  = 1'b1;
    logic [1:0] lvl_trig = 2'b01;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rd;
        logic       push;
        logic [7:0] din;
        logic       pop;
        logic [7:0] rbr;
        logic       dr;
        logic       rda;
    } vec_t;

    vec_t tv [12];

    task automatic cyc(input logic v, input logic [7:0] d, input logic rd,
                       input logic lsr, input logic tk, input logic frr);
        @(posedge clk);
        #1;
        rst         = lvl_rst;
        fcr_fifo_en = lvl_en;
        fcr_trig    = lvl_trig;
        rx_valid    = v;
        rx_data     = d;
        rbr_rd      = rd;
        lsr_rd      = lsr;
        char_tick   = tk;
        fcr_rx_rst  = frr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fcr_fifo_en = 1'b1; fcr_trig = 2'b01; fcr_rx_rst = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; char_tick = 1'b0; rbr_rd = 1'b0; lsr_rd = 1'b0;

        //                v     d      rd    push  din    pop   rbr    dr    rda
        tv[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 8'h43, 1'b0, 1'b1, 8'h42, 1'b0, 8'h41, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h43, 1'b0, 8'h41, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 8'h41, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0};
        tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset held, then released: fifo_rst stays high for one cycle after release.
        idle();
        chk("rst fifo_rst", 8'(fifo_rst), 8'h01);
        chk("rst push", 8'(fifo_push), 8'h00);
        chk("rst pop", 8'(fifo_pop), 8'h00);
        chk("rst data_ready", 8'(data_ready), 8'h00);
        chk("rst overrun", 8'(overrun_err), 8'h00);
        chk("rst irq_cti", 8'(irq_cti), 8'h00);
        chk("rst threshold", 8'(fifo_threshold), 8'h00);
        idle();
        lvl_rst = 1'b0;
        idle();
        chk("flush cycle fifo_rst", 8'(fifo_rst), 8'h01);
        idle();
        chk("post flush fifo_rst", 8'(fifo_rst), 8'h00);
        chk("post flush data_ready", 8'(data_ready), 8'h00);
        chk("post flush irq_rda", 8'(irq_rda), 8'h00);
        chk("post flush irq_cti", 8'(irq_cti), 8'h00);
        chk("post flush overrun", 8'(overrun_err), 8'h00);
        chk("post flush threshold", 8'(fifo_threshold), 8'h03);

        // Trigger level 4: table of pushes then reads.
        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].v, tv[i].d, tv[i].rd, 1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d push", i), 8'(fifo_push), 8'(tv[i].push));
            if (tv[i].push) chk($sformatf("v%0d din", i), fifo_din, tv[i].din);
            chk($sformatf("v%0d pop", i), 8'(fifo_pop), 8'(tv[i].pop));
            chk($sformatf("v%0d rbr_data", i), rbr_data, tv[i].rbr);
            chk($sformatf("v%0d data_ready", i), 8'(data_ready), 8'(tv[i].dr));
            chk($sformatf("v%0d irq_rda", i), 8'(irq_rda), 8'(tv[i].rda));
            chk($sformatf("v%0d overrun", i), 8'(overrun_err), 8'h00);
        end

        // Character timeout after four idle character times.
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("cti push", 8'(fifo_push), 8'h01);
        idle();
        for (int t = 0; t < 4; t++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("cti tick%0d irq_cti", t), 8'(irq_cti), 8'h00);
            if (t < 3) idle();
        end
        idle();
        chk("cti pre irq_cti", 8'(irq_cti), 8'h00);
        idle();
        chk("cti irq_cti", 8'(irq_cti), 8'(CTI_ON));
        chk("cti data_ready", 8'(data_ready), 8'h01);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cti read pop", 8'(fifo_pop), 8'h01);
        chk("cti read rbr", rbr_data, 8'h55);
        idle();
        chk("cti cleared", 8'(irq_cti), 8'h00);
        chk("cti data_ready", 8'(data_ready), 8'h00);

        // Overrun: 17 characters into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i >= 1) begin
                chk($sformatf("ovr push%0d", i - 1), 8'(fifo_push), 8'h01);
                chk($sformatf("ovr din%0d", i - 1), fifo_din, 8'(i - 1));
            end
        end
        idle();
        chk("ovr blocked push", 8'(fifo_push), 8'h00);
        chk("ovr not yet", 8'(overrun_err), 8'h00);
        idle();
        chk("ovr set", 8'(overrun_err), 8'h01);
        chk("ovr head", rbr_data, 8'h00);
        chk("ovr irq_rda", 8'(irq_rda), 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr during lsr_rd", 8'(overrun_err), 8'h01);
        idle();
        chk("ovr cleared", 8'(overrun_err), 8'h00);
        chk("ovr head kept", rbr_data, 8'h00);

        // Holding-register mode: toggling fcr_fifo_en flushes for one cycle.
        lvl_en = 1'b0;
        idle();
        chk("nf pre flush", 8'(fifo_rst), 8'h00);
        idle();
        chk("nf flush", 8'(fifo_rst), 8'h01);
        chk("nf flush data_ready", 8'(data_ready), 8'h00);
        idle();
        chk("nf flush done", 8'(fifo_rst), 8'h00);
        chk("nf empty", 8'(data_ready), 8'h00);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("nf push A5", 8'(fifo_push), 8'h01);
        chk("nf din A5", fifo_din, 8'hA5);
        idle();
        chk("nf data_ready", 8'(data_ready), 8'h01);
        chk("nf irq_rda", 8'(irq_rda), 8'h01);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("nf push 5A blocked", 8'(fifo_push), 8'h00);
        idle();
        chk("nf overrun", 8'(overrun_err), 8'h01);
        chk("nf rbr", rbr_data, 8'hA5);

        // Mid-operation FCR RX reset coincident with an incoming character.
        lvl_en = 1'b1;
        idle();
        idle();
        chk("mf mode flush", 8'(fifo_rst), 8'h01);
        idle();
        chk("mf empty", 8'(data_ready), 8'h00);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mf push 11", 8'(fifo_push), 8'h01);
        cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mf push 22", 8'(fifo_push), 8'h01);
        chk("mf rbr", rbr_data, 8'h11);
        idle();
        chk("mf flush", 8'(fifo_rst), 8'h01);
        chk("mf 33 dropped", 8'(fifo_push), 8'h00);
        idle();
        chk("mf no late push", 8'(fifo_push), 8'h00);
        chk("mf data_ready", 8'(data_ready), 8'h00);
        chk("mf overrun kept", 8'(overrun_err), 8'h01);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("mf overrun cleared", 8'(overrun_err), 8'h00);

        // Threshold decode updates one cycle after fcr_trig changes.
        begin
            logic [1:0] codes [3];
            logic [7:0] exp_th [3];
            logic [7:0] prev_th;
            codes[0] = 2'b10; exp_th[0] = 8'd7;
            codes[1] = 2'b11; exp_th[1] = 8'd13;
            codes[2] = 2'b00; exp_th[2] = 8'd0;
            prev_th = 8'd3;
            for (int k = 0; k < 3; k++) begin
                lvl_trig = codes[k];
                idle();
                chk($sformatf("trig%0d old", k), 8'(fifo_threshold), prev_th);
                idle();
                chk($sformatf("trig%0d new", k), 8'(fifo_threshold), exp_th[k]);
                prev_th = exp_th[k];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
